// File: rtl/vmask_gen.sv
// Mask-stream generator: emits ceil(N/E) byte-lane mask beats with the first N elements active.
// Optional VMASK_GEN_INVERT_EN adds in_invert to complement the element lanes of every beat.
module vmask_gen #(
    parameter int unsigned REQ_DATA_WIDTH = 64,
    parameter int unsigned REQ_ADDR_WIDTH = 32,
    parameter int unsigned SEW_WIDTH      = 2,
    parameter int unsigned COUNT_WIDTH    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [COUNT_WIDTH-1:0]      in_count,
    input  logic [SEW_WIDTH-1:0]        in_sew,
    input  logic [REQ_ADDR_WIDTH-1:0]   in_addr,
`ifdef VMASK_GEN_INVERT_EN
    input  logic                        in_invert,
`endif
    output logic [REQ_DATA_WIDTH/8-1:0] out_m0,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_start,
    output logic                        out_end,
    output logic [REQ_ADDR_WIDTH-1:0]   out_addr
);

    localparam int unsigned Lanes = REQ_DATA_WIDTH / 8;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e                    state_q, state_d;
    logic [SEW_WIDTH-1:0]      sew_q, sew_d;
    logic                      inv_q, inv_d;
    logic [COUNT_WIDTH-1:0]    rem_q, rem_d;
    logic [Lanes-1:0]          m0_q, m0_d;
    logic                      start_q, start_d;
    logic                      end_q, end_d;
    logic [REQ_ADDR_WIDTH-1:0] addr_q, addr_d;

    logic                      in_inv;
    logic                      accept;
    logic                      xfer;
    logic                      load;
    logic [COUNT_WIDTH-1:0]    src_cnt;
    logic [SEW_WIDTH-1:0]      src_sew;
    logic                      src_inv;
    logic [COUNT_WIDTH-1:0]    src_epb;

`ifdef VMASK_GEN_INVERT_EN
    assign in_inv = in_invert;
`else
    assign in_inv = 1'b0;
`endif

    // Element k sits at lane k << sew; lanes between elements are always 0.
    function automatic logic [Lanes-1:0] lane_mask(input logic [COUNT_WIDTH-1:0] cnt,
                                                   input logic [SEW_WIDTH-1:0]   sew,
                                                   input logic                   inv);
        logic [Lanes-1:0] m;
        int unsigned      stride;
        m      = '0;
        stride = 32'd1 << sew;
        for (int unsigned i = 0; i < Lanes; i++) begin
            if ((i & (stride - 32'd1)) == 32'd0) begin
                m[i] = ((i >> sew) < 32'(cnt)) ^ inv;
            end
        end
        return m;
    endfunction

    // The end beat may be replaced by a new request's first beat in the same cycle.
    assign in_ready = !rst && ((state_q == StIdle) || (out_ready && end_q));
    assign accept   = in_valid && in_ready;
    assign xfer     = (state_q == StRun) && out_ready;

    always_comb begin
        state_d = state_q;
        sew_d   = sew_q;
        inv_d   = inv_q;
        rem_d   = rem_q;
        m0_d    = m0_q;
        start_d = start_q;
        end_d   = end_q;
        addr_d  = addr_q;
        load    = 1'b0;
        src_cnt = rem_q;
        src_sew = sew_q;
        src_inv = inv_q;

        if (accept) begin
            load    = 1'b1;
            src_cnt = in_count;
            src_sew = in_sew;
            src_inv = in_inv;
            sew_d   = in_sew;
            inv_d   = in_inv;
            start_d = 1'b1;
            addr_d  = in_addr;
            state_d = StRun;
        end else if (xfer) begin
            if (end_q) begin
                state_d = StIdle;
            end else begin
                load    = 1'b1;
                start_d = 1'b0;
                addr_d  = addr_q + REQ_ADDR_WIDTH'(1);
            end
        end

        src_epb = COUNT_WIDTH'(Lanes) >> src_sew;
        if (load) begin
            m0_d  = lane_mask(src_cnt, src_sew, src_inv);
            end_d = (src_cnt <= src_epb);
            rem_d = (src_cnt > src_epb) ? (src_cnt - src_epb) : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            sew_q   <= '0;
            inv_q   <= 1'b0;
            rem_q   <= '0;
            m0_q    <= '0;
            start_q <= 1'b0;
            end_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            sew_q   <= sew_d;
            inv_q   <= inv_d;
            rem_q   <= rem_d;
            m0_q    <= m0_d;
            start_q <= start_d;
            end_q   <= end_d;
            addr_q  <= addr_d;
        end
    end

    assign out_valid = (state_q == StRun);
    assign out_m0    = m0_q;
    assign out_start = start_q;
    assign out_end   = end_q;
    assign out_addr  = addr_q;

endmodule

// File: tb/tb_vmask_gen.sv
// Directed self-checking bench for vmask_gen; inputs driven and outputs sampled on the falling edge.
module tb_vmask_gen;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_count;
    logic [1:0]  in_sew;
    logic [31:0] in_addr;
    logic        in_invert;
    logic [7:0]  out_m0;
    logic        out_valid;
    logic        out_ready;
    logic        out_start;
    logic        out_end;
    logic [31:0] out_addr;

    int n_checks = 0;
    int n_pass   = 0;

    vmask_gen dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_count  (in_count),
        .in_sew    (in_sew),
        .in_addr   (in_addr),
`ifdef VMASK_GEN_INVERT_EN
        .in_invert (in_invert),
`endif
        .out_m0    (out_m0),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_start (out_start),
        .out_end   (out_end),
        .out_addr  (out_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic chk_beat(input string tag, input logic [7:0] m0, input logic [31:0] addr,
                            input logic st, input logic en);
        check({tag, ".valid"}, 64'(out_valid), 64'd1);
        check({tag, ".m0"},    64'(out_m0),    64'(m0));
        check({tag, ".addr"},  64'(out_addr),  64'(addr));
        check({tag, ".start"}, 64'(out_start), 64'(st));
        check({tag, ".end"},   64'(out_end),   64'(en));
    endtask

    // Present a request at the current falling edge; it is accepted on the next rising edge.
    task automatic req(input logic [15:0] n, input logic [1:0] sew, input logic [31:0] addr,
                       input logic inv);
        in_valid  = 1'b1;
        in_count  = n;
        in_sew    = sew;
        in_addr   = addr;
        in_invert = inv;
    endtask

    task automatic step();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_count  = '0;
        in_sew    = '0;
        in_addr   = '0;
        in_invert = 1'b0;
        out_ready = 1'b1;
        #12;
        check("rst.in_ready",  64'(in_ready),  64'd0);
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.out_m0",    64'(out_m0),    64'd0);
        check("rst.out_addr",  64'(out_addr),  64'd0);
        check("rst.out_end",   64'(out_end),   64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel.in_ready", 64'(in_ready), 64'd1);

        // N=11 sew8: full beat then 3 elements
        @(negedge clk);
        req(16'd11, 2'd0, 32'h100, 1'b0);
        step();
        chk_beat("t1.b1", 8'hFF, 32'h100, 1'b1, 1'b0);
        check("t1.busy_in_ready", 64'(in_ready), 64'd0);
        step();
        chk_beat("t1.b2", 8'h07, 32'h101, 1'b0, 1'b1);
        check("t1.end_in_ready", 64'(in_ready), 64'd1);
        step();
        check("t1.idle_valid", 64'(out_valid), 64'd0);

        // N=3 sew16
        req(16'd3, 2'd1, 32'h40, 1'b0);
        step();
        chk_beat("t2.b1", 8'h15, 32'h40, 1'b1, 1'b1);
        step();
        check("t2.idle_valid", 64'(out_valid), 64'd0);

        // N=0 sew32, then N=2 sew32 back-to-back
        req(16'd0, 2'd2, 32'h80, 1'b0);
        step();
        chk_beat("t3.b0", 8'h00, 32'h80, 1'b1, 1'b1);
        check("t3.b2b_in_ready", 64'(in_ready), 64'd1);
        req(16'd2, 2'd2, 32'h90, 1'b0);
        step();
        chk_beat("t3.b1", 8'h11, 32'h90, 1'b1, 1'b1);
        step();
        check("t3.idle_valid", 64'(out_valid), 64'd0);

        // N=5 sew64 with a 3-cycle stall on beat 2; busy-time inputs ignored
        req(16'd5, 2'd3, 32'h20, 1'b0);
        step();
        chk_beat("t4.b1", 8'h01, 32'h20, 1'b1, 1'b0);
        step();
        out_ready = 1'b0;
        chk_beat("t4.b2", 8'h01, 32'h21, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            req(16'd99, 2'd0, 32'hDEAD, 1'b0);
            step();
            chk_beat($sformatf("t4.stall%0d", i), 8'h01, 32'h21, 1'b0, 1'b0);
            check("t4.stall_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        step();
        chk_beat("t4.b3", 8'h01, 32'h22, 1'b0, 1'b0);
        step();
        chk_beat("t4.b4", 8'h01, 32'h23, 1'b0, 1'b0);
        step();
        chk_beat("t4.b5", 8'h01, 32'h24, 1'b0, 1'b1);
        step();
        check("t4.idle_valid", 64'(out_valid), 64'd0);

        // Address wrap
        req(16'd16, 2'd0, 32'hFFFF_FFFF, 1'b0);
        step();
        chk_beat("t5.b1", 8'hFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        step();
        chk_beat("t5.b2", 8'hFF, 32'h0000_0000, 1'b0, 1'b1);
        step();
        check("t5.idle_valid", 64'(out_valid), 64'd0);

        // Reset during beat 3 of N=40
        req(16'd40, 2'd0, 32'h200, 1'b0);
        step();
        chk_beat("t6.b1", 8'hFF, 32'h200, 1'b1, 1'b0);
        step();
        step();
        chk_beat("t6.b3", 8'hFF, 32'h202, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("t6.rst_valid",    64'(out_valid), 64'd0);
        check("t6.rst_end",      64'(out_end),   64'd0);
        check("t6.rst_m0",       64'(out_m0),    64'd0);
        check("t6.rst_in_ready", 64'(in_ready),  64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t6.rel_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        check("t6.rel_valid", 64'(out_valid), 64'd0);
        req(16'd1, 2'd0, 32'h300, 1'b0);
        step();
        chk_beat("t6.new", 8'h01, 32'h300, 1'b1, 1'b1);
        step();
        check("t6.idle_valid", 64'(out_valid), 64'd0);

`ifdef VMASK_GEN_INVERT_EN
        // Inverted: N=3 sew16 -> only element 3 (lane 6) set; N=0 sew32 -> lanes 0 and 4
        req(16'd3, 2'd1, 32'h500, 1'b1);
        step();
        chk_beat("t7.inv", 8'h40, 32'h500, 1'b1, 1'b1);
        step();
        req(16'd0, 2'd2, 32'h600, 1'b1);
        step();
        chk_beat("t7.inv0", 8'h11, 32'h600, 1'b1, 1'b1);
        step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vmask_gen.md
Name: vmask_gen

Overview:
Mask-stream generator for the vALU. It is the transmit-side counterpart of the mask-popcount path, which consumes mask beats and reduces them to a count. This block takes a scalar element count N and emits a stream of mask beats with the first N elements active. Beats use the same per-SEW byte-lane mask layout, with out_start, out_end and word addresses, so its output can feed the mask consumers directly (vl/tail mask, vmset-style results).

Parameters:
REQ_DATA_WIDTH, 64, data word width; the mask has REQ_DATA_WIDTH/8 byte-lane bits per beat
REQ_ADDR_WIDTH, 32, beat address width
SEW_WIDTH, 2, SEW encoding width (0=8b, 1=16b, 2=32b, 3=64b)
COUNT_WIDTH, 16, element count width

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid & in_ready
in_count  in  COUNT_WIDTH  number of active elements N
in_sew  in  SEW_WIDTH  element width
in_addr  in  REQ_ADDR_WIDTH  address of first beat
out_m0  out  REQ_DATA_WIDTH/8  byte-lane mask for the beat
out_valid  out  1  beat valid
out_ready  in  1  downstream accepts the beat
out_start  out  1  first beat of the request
out_end  out  1  last beat of the request
out_addr  out  REQ_ADDR_WIDTH  beat address

Behaviour:
- Reset values (async, active-high): out_m0=0, out_valid=0, out_start=0, out_end=0, out_addr=0, state=IDLE. in_ready is 0 during reset and 1 in the first cycle after deassert.
- Elements per beat E: 8 for sew 0, 4 for sew 1, 2 for sew 2, 1 for sew 3.
- Element k of a beat maps to lane bit k*(8/E). Active elements set their lane bit; all other lane bits are 0.
  - sew1: bits 0,2,4,6.
  - sew2: bits 0,4.
  - sew3: bit 0.
- Beats per request B = ceil(N/E). When N=0, B=1 with an all-zero mask.
- FSM IDLE:
  - in_ready=1.
  - On accept, latch sew, remaining=N and addr=in_addr, then go to RUN.
  - The first beat is registered and out_valid rises the cycle after accept (latency 1).
- FSM RUN:
  - in_ready=0.
  - Beat mask = lanes for min(remaining,E) elements; out_addr = base + beat index, wrapping modulo 2^REQ_ADDR_WIDTH.
  - out_start=1 on beat 0 only; out_end=1 when remaining<=E (always on the N=0 beat).
- Beat transfer:
  - A beat transfers on out_valid & out_ready; remaining decrements by E, saturating at 0.
  - While out_valid & !out_ready, out_m0, out_start, out_end and out_addr hold stable.
- End of request: transfer of the out_end beat returns the FSM to IDLE and out_valid drops the next cycle, unless a new request is accepted in that cycle.
- Back-to-back: in_ready is also 1 in the cycle the out_end beat transfers. A request accepted then produces its first beat on the following cycle with no bubble.
- Request fields are sampled only at accept. Input changes while busy are ignored.
- Reset asserted mid-request aborts immediately: all outputs clear asynchronously and no partial end beat is produced.

Optional Feature:
Macro VMASK_GEN_INVERT_EN.
- Defined: adds input in_invert (1 bit), latched at accept. When latched 1, the selected element lane bits are complemented (active elements 0, tail elements 1). Non-element lanes stay 0, and for N=0 the single beat carries all element lanes set.
- Undefined: the port is absent and the behaviour is as above.

Test Plan:
- N=11, sew=0, addr=0x100, out_ready=1 -> beat1 m0=0xFF addr=0x100 start=1 end=0; beat2 m0=0x07 addr=0x101 start=0 end=1; in_ready back to 1.
- N=3, sew=1, addr=0x40 -> single beat m0=0x15, start=1, end=1, addr=0x40.
- N=0, sew=2 -> single beat m0=0x00, start=1, end=1. Then N=2, sew=2 back-to-back -> next cycle m0=0x11 start=1 end=1, no bubble.
- N=5, sew=3, addr=0x20, out_ready low for 3 cycles on beat 2 -> beats m0=0x01 at addr 0x20..0x24; beat 2 holds stable while stalled; end=1 only at 0x24.
- addr=0xFFFFFFFF, N=16, sew=0 -> beats at 0xFFFFFFFF then 0x00000000, both m0=0xFF, end on the second.
- Reset pulse during beat 3 of N=40, sew=0 -> out_valid=0 asynchronously, no end beat. After release, in_ready=1 and a new N=1 request gives m0=0x01.
